// File: rtl/i2sin.sv
// I2S-style serial receiver: deserialises ws/sd (MSB first, ws low = left) into
// parallel stereo samples with a one-cycle data_valid pulse per well-formed frame.
module i2sin #(
    parameter int unsigned BITS_PRECISION = 24
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      ws,
    input  logic                      sd,
    output logic [BITS_PRECISION-1:0] l_data,
    output logic [BITS_PRECISION-1:0] r_data,
    output logic                      data_valid,
    output logic                      frame_error
);

    localparam int unsigned N  = BITS_PRECISION;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RIGHT = 2'd1,
        DONE  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            ws_prev;
    logic [CW-1:0]   lo_cnt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [N-1:0]    left_sr;
    logic [N-1:0]    left_hold, left_hold_nxt;
    logic [N-1:0]    right_sr, right_sr_nxt;
    logic [N-1:0]    l_data_nxt, r_data_nxt;
    logic            data_valid_nxt, frame_error_nxt;

    // Left capture runs regardless of state, so a frame following idle
    // (no ws falling edge) still yields the last N low samples.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            ws_prev <= 1'b1;
            lo_cnt  <= '0;
            left_sr <= '0;
        end else begin
            ws_prev <= ws;
            if (!ws) begin
                left_sr <= {left_sr[N-2:0], sd};
                if (lo_cnt != CW'(N)) begin
                    lo_cnt <= lo_cnt + CW'(1);
                end
            end else begin
                lo_cnt <= '0;
            end
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            left_hold   <= '0;
            right_sr    <= '0;
            l_data      <= '0;
            r_data      <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            left_hold   <= left_hold_nxt;
            right_sr    <= right_sr_nxt;
            l_data      <= l_data_nxt;
            r_data      <= r_data_nxt;
            data_valid  <= data_valid_nxt;
            frame_error <= frame_error_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        left_hold_nxt   = left_hold;
        right_sr_nxt    = right_sr;
        l_data_nxt      = l_data;
        r_data_nxt      = r_data;
        data_valid_nxt  = 1'b0;
        frame_error_nxt = 1'b0;

        case (state)
            HUNT: begin
                if (ws && !ws_prev) begin
                    if (lo_cnt == CW'(N)) begin
                        left_hold_nxt = left_sr;
                        right_sr_nxt  = {{(N-1){1'b0}}, sd};
                        bit_cnt_nxt   = CW'(1);
                        state_nxt     = RIGHT;
                    end else begin
                        frame_error_nxt = 1'b1;
                        state_nxt       = SKIP;
                    end
                end
            end
            RIGHT: begin
                if (ws) begin
                    right_sr_nxt = {right_sr[N-2:0], sd};
                    bit_cnt_nxt  = bit_cnt + CW'(1);
                    if (bit_cnt_nxt == CW'(N)) begin
                        r_data_nxt     = right_sr_nxt;
                        l_data_nxt     = left_hold;
                        data_valid_nxt = 1'b1;
                        state_nxt      = DONE;
                    end
                end else begin
                    frame_error_nxt = 1'b1;
                    state_nxt       = HUNT;
                end
            end
            DONE: begin
                if (!ws) begin
                    state_nxt = HUNT;
                end
            end
            SKIP: begin
                if (!ws) begin
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

endmodule

// File: tb/tb_i2sin.sv
// Directed bench for i2sin (N=24): a behavioural transmitter drives ws/sd on
// negedge sck while a monitor records every data_valid / frame_error pulse.
module tb_i2sin;

    localparam int unsigned N = 24;

    logic          sck = 1'b0;
    logic          rst = 1'b1;
    logic          ws  = 1'b0;
    logic          sd  = 1'b0;
    logic [N-1:0]  l_data;
    logic [N-1:0]  r_data;
    logic          data_valid;
    logic          frame_error;

    int errors = 0;
    int checks = 0;

    int cyc      = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int dv_cyc[$];
    logic [N-1:0] dv_l[$];
    logic [N-1:0] dv_r[$];

    i2sin #(.BITS_PRECISION(N)) dut (
        .sck         (sck),
        .rst         (rst),
        .ws          (ws),
        .sd          (sd),
        .l_data      (l_data),
        .r_data      (r_data),
        .data_valid  (data_valid),
        .frame_error (frame_error)
    );

    always #5 sck = ~sck;

    // Pulse monitor, sampling just after each active edge.
    always @(posedge sck) begin
        #1;
        cyc++;
        if (data_valid) begin
            dv_cnt++;
            dv_cyc.push_back(cyc);
            dv_l.push_back(l_data);
            dv_r.push_back(r_data);
        end
        if (frame_error) fe_cnt++;
        if (data_valid && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic w, input logic b);
        @(negedge sck);
        ws = w;
        sd = b;
    endtask

    // Sends nbits with ws=w; bits past N are filler.
    task automatic send_word(input logic w, input logic [N-1:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i < int'(N)) send_bit(w, d[N-1-i]);
            else             send_bit(w, 1'(i % 2));
        end
    endtask

    task automatic send_frame(input logic [N-1:0] l, input logic [N-1:0] r);
        send_word(1'b0, l, N);
        send_word(1'b1, r, N);
    endtask

    // Wait past the edge that samples the last driven bit and the monitor.
    task automatic settle();
        @(posedge sck);
        #2;
    endtask

    int dv0, fe0;

    initial begin
        // Reset state
        repeat (3) @(negedge sck);
        check("rst_l", 32'(l_data), 32'h0);
        check("rst_r", 32'(r_data), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_fe", 32'(frame_error), 32'h0);
        rst = 1'b0;

        // Idle: no pulses
        repeat (30) send_bit(1'b0, 1'b0);
        settle();
        check("idle_dv", 32'(dv_cnt), 32'd0);
        check("idle_fe", 32'(fe_cnt), 32'd0);

        // Frame from idle
        send_frame(24'hABCDEF, 24'h123456);
        settle();
        check("f1_dv_now", 32'(data_valid), 32'h1);
        check("f1_l", 32'(l_data), 32'hABCDEF);
        check("f1_r", 32'(r_data), 32'h123456);
        check("f1_dv_cnt", 32'(dv_cnt), 32'd1);
        check("f1_fe_cnt", 32'(fe_cnt), 32'd0);

        // Back-to-back frames
        dv_cyc.delete(); dv_l.delete(); dv_r.delete();
        dv0 = dv_cnt;
        send_frame(24'h800001, 24'h7FFFFF);
        send_frame(24'h000000, 24'hFFFFFF);
        send_frame(24'h5A5A5A, 24'hA5A5A5);
        settle();
        send_bit(1'b1, 1'b0);
        settle();
        check("lb_dv_cnt", 32'(dv_cnt - dv0), 32'd3);
        check("lb_fe_cnt", 32'(fe_cnt), 32'd0);
        check("lb_dv_held", 32'(data_valid), 32'h0);
        if (dv_cyc.size() == 3) begin
            check("lb_gap0", 32'(dv_cyc[1] - dv_cyc[0]), 32'd48);
            check("lb_gap1", 32'(dv_cyc[2] - dv_cyc[1]), 32'd48);
            check("lb_l0", 32'(dv_l[0]), 32'h800001);
            check("lb_r0", 32'(dv_r[0]), 32'h7FFFFF);
            check("lb_l1", 32'(dv_l[1]), 32'h000000);
            check("lb_r1", 32'(dv_r[1]), 32'hFFFFFF);
            check("lb_l2", 32'(dv_l[2]), 32'h5A5A5A);
            check("lb_r2", 32'(dv_r[2]), 32'hA5A5A5);
        end

        // Truncated right word
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_word(1'b0, 24'h111111, N);
        send_word(1'b1, 24'h222222, 10);
        send_bit(1'b0, 1'b0);
        settle();
        check("tr_fe_now", 32'(frame_error), 32'h1);
        check("tr_dv_now", 32'(data_valid), 32'h0);
        check("tr_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        check("tr_dv_cnt", 32'(dv_cnt - dv0), 32'd0);
        check("tr_l_held", 32'(l_data), 32'h5A5A5A);
        check("tr_r_held", 32'(r_data), 32'hA5A5A5);

        // Short left word after reset
        @(negedge sck);
        rst = 1'b1; ws = 1'b0; sd = 1'b0;
        repeat (2) @(negedge sck);
        rst = 1'b0;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_word(1'b0, 24'hFFFFFF, 5);
        send_bit(1'b1, 1'b1);
        settle();
        check("sl_fe_now", 32'(frame_error), 32'h1);
        check("sl_l", 32'(l_data), 32'h0);
        send_word(1'b1, 24'h0, 5);
        send_frame(24'hC0FFEE, 24'h0BEEF1);
        settle();
        check("sl_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        check("sl_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("sl_l2", 32'(l_data), 32'hC0FFEE);
        check("sl_r2", 32'(r_data), 32'h0BEEF1);

        // Overlong right word
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_word(1'b0, 24'h13579B, N);
        send_word(1'b1, 24'h2468AC, 30);
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        settle();
        check("ol_dv_cnt", 32'(dv_cnt - dv0), 32'd2);
        check("ol_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
        if (dv_l.size() >= 2) begin
            check("ol_l0", 32'(dv_l[dv_l.size()-2]), 32'h13579B);
            check("ol_r0", 32'(dv_r[dv_r.size()-2]), 32'h2468AC);
        end
        check("ol_l1", 32'(l_data), 32'h0F0F0F);
        check("ol_r1", 32'(r_data), 32'hF0F0F0);

        // Reset mid-frame
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_word(1'b0, 24'hDEADBE, N);
        send_word(1'b1, 24'h777777, 12);
        @(negedge sck);
        rst = 1'b1; ws = 1'b0; sd = 1'b0;
        #1;
        check("rm_l", 32'(l_data), 32'h0);
        check("rm_r", 32'(r_data), 32'h0);
        repeat (2) @(negedge sck);
        rst = 1'b0;
        send_frame(24'h654321, 24'h0ABCDE);
        settle();
        check("rm_dv_cnt", 32'(dv_cnt - dv0), 32'd1);
        check("rm_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
        check("rm_l2", 32'(l_data), 32'h654321);
        check("rm_r2", 32'(r_data), 32'h0ABCDE);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
